tone_square_gen: RTL
====================

// Module: tone_square_gen
// PURPOSE
//  Downstream of the sound-select mux: turns the 4-bit sound code plus its enable into an audible
//  square wave. Each code indexes a note-period table. Note changes and stops happen only at wave
//  boundaries, so the output never glitches. Drives the 1-bit speaker pin and an 8-bit signed
//  sample for the audio codec path.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  clk frequency; note half-periods are derived from it
//  AMPLITUDE    64          magnitude of audio_sample while playing (1..127)
//  CNT_W        20          half-period counter width; must hold CLK_FREQ_HZ/(2*262)
// PORTS
//  clk           in   1      system clock (single clock domain)
//  reset         in   1      synchronous, active-high reset
//  enable_sound  in   1      sound request from the sound-select mux, level
//  sound         in   4      note code; 0 = silence, 1..15 = notes
//  audio_sq      out  1      square wave to speaker pin
//  audio_sample  out  8      signed sample: +AMPLITUDE / -AMPLITUDE while playing, 0 when idle
//  active        out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset (sync, active-high; wins over all other inputs in the same cycle)
//   - state=IDLE; cnt=0; cur_code=0; pend_code=0; audio_sq=0; audio_sample=0; active=0.
//  Note table: codes 1..15 map to 262,294,330,349,392,440,494,523,587,659,698,784,880,988,1047 Hz.
//   - HP(code) = max(1, CLK_FREQ_HZ / (2*f)), integer floor. HP(0) is unused.
//  Request: req = enable_sound && sound != 0. pend_code <= sound every cycle that req is high.
//  IDLE
//   - If req is sampled at edge N: cur_code <= sound; cnt <= HP(sound)-1; audio_sq <= 1;
//     state <= PLAY.
//   - audio_sq is high from edge N, so latency is 1 cycle.
//  PLAY / DRAIN, each cycle
//   - If cnt != 0: cnt <= cnt-1.
//   - If cnt == 0 (half boundary): audio_sq <= ~audio_sq.
//     - cur_code <= pend_code (PLAY only); cnt <= HP(new cur_code)-1.
//     - A code change therefore takes effect at the next half boundary, never mid-half.
//  PLAY -> DRAIN when req is low in any cycle; pend_code keeps its last value.
//  DRAIN
//   - Req high again -> PLAY, with no phase reset.
//   - Boundary with audio_sq==1 -> toggle to 0 and play the low half with cur_code's period.
//   - Boundary with audio_sq==0 -> IDLE; audio_sq stays 0.
//   - A period always completes, so there is no DC step.
//  audio_sample
//   - IDLE: 0.
//   - Otherwise: audio_sq ? AMPLITUDE : -AMPLITUDE (8-bit two's complement), registered with audio_sq.
//  Edge cases
//   - enable high with sound==0 is treated as req low.
//   - Code change and req drop in the same cycle: the drop wins and pend_code is not updated.
//   - cnt never wraps; it is always reloaded at 0.
//   - Reset mid-wave forces audio_sq=0 immediately on the reset edge.
// STRUCTURE
//  Package sound_pkg
//   - typedef logic [3:0] sound_code_t; typedef enum {IDLE, PLAY, DRAIN} tone_state_t.
//   - localparam int NOTE_HZ[16] table.
//   - function half_period(code, clk_hz) with the clamp to 1.
//  Sub-module tone_period_rom (combinational): code in -> HP-1 out (CNT_W bits).
//   - Instantiated twice: once for the IDLE load, once for the boundary reload from pend_code.
//  Top: one FSM always_ff, counter, output registers.
// TESTING (CLK_FREQ_HZ=8800 => HP(6)=10, HP(1)=16, HP(15)=4)
//  1. Reset with enable=1, sound=6 -> all outputs 0 during reset.
//     Release -> audio_sq high 1 cycle after the first sampled req.
//  2. enable=1, sound=6 held -> audio_sq alternates 10 high / 10 low cycles.
//     audio_sample alternates +64 / -64; active=1.
//  3. Switch sound 6->15 on the 3rd cycle of a high half -> that half stays 10 cycles.
//     Following halves are 4 cycles.
//  4. Drop enable on the 2nd cycle of a high half (code 6) -> 8 more high + 10 low cycles.
//     Then IDLE, audio_sq=0, audio_sample=0, active=0.
//  5. Re-raise enable during the DRAIN low half -> no gap; the next high half starts on schedule.
//  6. sound=0 with enable=1 from IDLE -> stays IDLE.
//     Reset asserted mid-PLAY -> audio_sq=0 and state IDLE on that edge.

Source files
------------

// File: rtl/tone_square_gen_pkg.sv
// Shared types, note table and half-period helper for the square-wave tone generator.
package sound_pkg;

  typedef logic [3:0] sound_code_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DRAIN
  } tone_state_t;

  // Code 0 is silence and never indexes a real note.
  localparam int NOTE_HZ [16] = '{
    0,   262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988, 1047
  };

  function automatic int half_period(sound_code_t code, int clk_hz);
    int hp;
    if (NOTE_HZ[code] == 0) begin
      return 1;
    end
    hp = clk_hz / (2 * NOTE_HZ[code]);
    return (hp < 1) ? 1 : hp;
  endfunction

endpackage

// File: rtl/tone_square_gen_if.sv
// Request/audio bundle between the sound-select mux, the tone generator and the audio outputs.
interface tone_square_gen_if;
  import sound_pkg::*;

  logic               enable_sound;
  sound_code_t        sound;
  logic               audio_sq;
  logic signed [7:0]  audio_sample;
  logic               active;

  modport master (
    output enable_sound,
    output sound,
    input  audio_sq,
    input  audio_sample,
    input  active
  );

  modport slave (
    input  enable_sound,
    input  sound,
    output audio_sq,
    output audio_sample,
    output active
  );

endinterface

// File: rtl/tone_square_gen_tone_period_rom.sv
// Combinational lookup: note code to half-period minus one, in counter-width bits.
module tone_period_rom
  import sound_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int CNT_W       = 20
) (
  input  sound_code_t      code_i,
  output logic [CNT_W-1:0] hp_m1_o
);

  always_comb begin
    hp_m1_o = CNT_W'(half_period(code_i, CLK_FREQ_HZ) - 1);
  end

endmodule

// File: rtl/tone_square_gen.sv
// Square-wave tone generator: notes start, change and stop only on half-period boundaries,
// so the speaker pin and codec sample never glitch or leave a DC step.
module tone_square_gen
  import sound_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int AMPLITUDE   = 64,
  parameter int CNT_W       = 20
) (
  input  logic              clk,
  input  logic              reset,
  tone_square_gen_if.slave  bus
);

  localparam logic signed [7:0] AMP_POS = 8'(AMPLITUDE);
  localparam logic signed [7:0] AMP_NEG = 8'(-AMPLITUDE);

  tone_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  sound_code_t        cur_code_q, cur_code_d;
  sound_code_t        pend_code_q, pend_code_d;
  logic               audio_sq_q, audio_sq_d;
  logic signed [7:0]  sample_q, sample_d;

  logic               req;
  logic               boundary;
  sound_code_t        reload_code;
  logic [CNT_W-1:0]   load_hp_m1;
  logic [CNT_W-1:0]   reload_hp_m1;

  assign req      = bus.enable_sound && (bus.sound != '0);
  assign boundary = (cnt_q == '0);

  // While draining, the pending code is frozen and the last note's period finishes the wave.
  assign reload_code = (state_q == PLAY) ? pend_code_q : cur_code_q;

  tone_period_rom #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .CNT_W       (CNT_W)
  ) u_load_rom (
    .code_i  (bus.sound),
    .hp_m1_o (load_hp_m1)
  );

  tone_period_rom #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .CNT_W       (CNT_W)
  ) u_reload_rom (
    .code_i  (reload_code),
    .hp_m1_o (reload_hp_m1)
  );

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_code_d  = cur_code_q;
    pend_code_d = pend_code_q;
    audio_sq_d  = audio_sq_q;

    if (req) begin
      pend_code_d = bus.sound;
    end

    unique case (state_q)
      IDLE: begin
        if (req) begin
          cur_code_d = bus.sound;
          cnt_d      = load_hp_m1;
          audio_sq_d = 1'b1;
          state_d    = PLAY;
        end
      end

      PLAY: begin
        if (!boundary) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          audio_sq_d = ~audio_sq_q;
          cur_code_d = pend_code_q;
          cnt_d      = reload_hp_m1;
        end
        if (!req) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (!boundary) begin
          cnt_d = cnt_q - 1'b1;
        end else if (audio_sq_q || req) begin
          audio_sq_d = ~audio_sq_q;
          cnt_d      = reload_hp_m1;
        end else begin
          state_d = IDLE;
        end
        if (req) begin
          state_d = PLAY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      sample_d = '0;
    end else begin
      sample_d = audio_sq_d ? AMP_POS : AMP_NEG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset is synchronous and overrides every other input on the same edge.
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_code_q  <= '0;
      pend_code_q <= '0;
      audio_sq_q  <= 1'b0;
      sample_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from the same _d values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_code_q  <= cur_code_d;
      pend_code_q <= pend_code_d;
      audio_sq_q  <= audio_sq_d;
      sample_q    <= sample_d;
    end
  end

  assign bus.audio_sq     = audio_sq_q;
  assign bus.audio_sample = sample_q;
  assign bus.active       = (state_q != IDLE);

endmodule
